// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WB   = 2'd1,
        REQ_MD   = 2'd2,
        REQ_IO   = 2'd3
    } req_e;

endpackage

// File: rtl/regfile_write_arbiter_starve_counter.sv
// Saturating wait counter; flags when the next edge will land on STARVE_LIMIT.
module starve_counter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit,
    output logic o_hit_next
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count == LIM);
    // High when this cycle's wait will leave the counter sitting at the limit.
    assign o_hit_next = i_inc && !i_clr && (r_count >= (LIM - 1'b1));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter: pipeline writeback first, mult/div and I/O round-robin, starvation stall.
// Optional grant/stall statistics outputs enabled by defining REGFILE_ARB_STATS_EN.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [REG_DATA_W-1:0] wb_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_reg,
    input  logic [REG_DATA_W-1:0] md_data,
    output logic                  md_ready,
    input  logic                  io_valid,
    input  logic [REG_ADDR_W-1:0] io_reg,
    input  logic [REG_DATA_W-1:0] io_data,
    output logic                  io_ready,
`ifdef REGFILE_ARB_STATS_EN
    output logic [15:0]           stat_md_grants,
    output logic [15:0]           stat_io_grants,
    output logic [15:0]           stat_stalls,
`endif
    output logic                  stall_pipeline,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [REG_DATA_W-1:0] data_writeReg
);

    req_e                  w_grant;
    req_e                  r_ptr;
    logic                  r_stall;
    logic                  w_md_trig;
    logic                  w_io_trig;
    logic                  w_md_at_limit;
    logic                  w_io_at_limit;
    logic                  w_md_hit_next;
    logic                  w_io_hit_next;
    logic [REG_ADDR_W-1:0] w_reg;
    logic [REG_DATA_W-1:0] w_data;

    assign w_md_trig = md_valid && w_md_at_limit;
    assign w_io_trig = io_valid && w_io_at_limit;

    always_comb begin
        w_grant = REQ_NONE;
        if (r_stall) begin
            // Stall slot belongs to the starved requester(s) only; writeback is held off.
            if (w_md_trig && w_io_trig) w_grant = r_ptr;
            else if (w_md_trig)         w_grant = REQ_MD;
            else if (w_io_trig)         w_grant = REQ_IO;
        end else if (wb_we) begin
            w_grant = REQ_WB;
        end else if (md_valid && io_valid) begin
            w_grant = r_ptr;
        end else if (md_valid) begin
            w_grant = REQ_MD;
        end else if (io_valid) begin
            w_grant = REQ_IO;
        end
    end

    always_comb begin
        w_reg  = wb_reg;
        w_data = wb_data;
        case (w_grant)
            REQ_MD: begin
                w_reg  = md_reg;
                w_data = md_data;
            end
            REQ_IO: begin
                w_reg  = io_reg;
                w_data = io_data;
            end
            default: ;
        endcase
    end

    assign md_ready = (w_grant == REQ_MD);
    assign io_ready = (w_grant == REQ_IO);

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_md_starve (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .i_inc      (md_valid && !md_ready),
        .i_clr      (md_ready || !md_valid),
        .o_at_limit (w_md_at_limit),
        .o_hit_next (w_md_hit_next)
    );

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_io_starve (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .i_inc      (io_valid && !io_ready),
        .i_clr      (io_ready || !io_valid),
        .o_at_limit (w_io_at_limit),
        .o_hit_next (w_io_hit_next)
    );

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_ptr            <= REQ_MD;
            r_stall          <= 1'b0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else begin
            r_stall <= !r_stall && (w_md_hit_next || w_io_hit_next);
            if (w_grant == REQ_MD) r_ptr <= REQ_IO;
            if (w_grant == REQ_IO) r_ptr <= REQ_MD;
            ctrl_writeEnable <= (w_grant != REQ_NONE) && (w_reg != REG_ZERO);
            if (w_grant != REQ_NONE) begin
                ctrl_writeReg <= w_reg;
                data_writeReg <= w_data;
            end
        end
    end

    assign stall_pipeline = r_stall;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] r_stat_md;
    logic [15:0] r_stat_io;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_stat_md    <= '0;
            r_stat_io    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (md_ready) r_stat_md    <= r_stat_md + 16'd1;
            if (io_ready) r_stat_io    <= r_stat_io + 16'd1;
            if (r_stall)  r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_md_grants = r_stat_md;
    assign stat_io_grants = r_stat_io;
    assign stat_stalls    = r_stat_stall;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic                  clock;
    logic                  ctrl_reset;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [REG_DATA_W-1:0] wb_data;
    logic                  md_valid;
    logic [REG_ADDR_W-1:0] md_reg;
    logic [REG_DATA_W-1:0] md_data;
    logic                  md_ready;
    logic                  io_valid;
    logic [REG_ADDR_W-1:0] io_reg;
    logic [REG_DATA_W-1:0] io_data;
    logic                  io_ready;
    logic                  stall_pipeline;
    logic                  ctrl_writeEnable;
    logic [REG_ADDR_W-1:0] ctrl_writeReg;
    logic [REG_DATA_W-1:0] data_writeReg;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0]           stat_md_grants;
    logic [15:0]           stat_io_grants;
    logic [15:0]           stat_stalls;
`endif

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(8), .CNT_W(8)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_we            (wb_we),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .io_valid         (io_valid),
        .io_reg           (io_reg),
        .io_data          (io_data),
        .io_ready         (io_ready),
`ifdef REGFILE_ARB_STATS_EN
        .stat_md_grants   (stat_md_grants),
        .stat_io_grants   (stat_io_grants),
        .stat_stalls      (stat_stalls),
`endif
        .stall_pipeline   (stall_pipeline),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ctrl_reset = 1'b0;
        wb_we = 1'b1;  wb_reg = 5'd5;  wb_data = 32'hAAAA0000;
        md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h11111111;
        io_valid = 1'b1; io_reg = 5'd4; io_data = 32'h22222222;
        repeat (3) tick();

        chk("rst_we",    32'(ctrl_writeEnable), 32'd0);
        chk("rst_reg",   32'(ctrl_writeReg),    32'd0);
        chk("rst_data",  data_writeReg,         32'd0);
        chk("rst_stall", 32'(stall_pipeline),   32'd0);

        // Post-reset: MD has pointer priority, then strict alternation.
        wb_we = 1'b0;
        ctrl_reset = 1'b1;
        #1;
        chk("first_md_ready", 32'(md_ready), 32'd1);
        chk("first_io_ready", 32'(io_ready), 32'd0);
        tick();
        chk("first_we",   32'(ctrl_writeEnable), 32'd1);
        chk("first_reg",  32'(ctrl_writeReg),    32'd3);
        chk("first_data", data_writeReg,         32'h11111111);
        chk("alt1_io_ready", 32'(io_ready), 32'd1);
        chk("alt1_md_ready", 32'(md_ready), 32'd0);
        tick();
        chk("alt1_reg",  32'(ctrl_writeReg), 32'd4);
        chk("alt1_data", data_writeReg,      32'h22222222);
        chk("alt2_md_ready", 32'(md_ready), 32'd1);
        tick();
        chk("alt2_reg", 32'(ctrl_writeReg), 32'd3);
        chk("alt3_io_ready", 32'(io_ready), 32'd1);
        tick();
        chk("alt3_reg", 32'(ctrl_writeReg), 32'd4);
        chk("alt3_we",  32'(ctrl_writeEnable), 32'd1);
        md_valid = 1'b0;
        io_valid = 1'b0;
        tick();
        chk("idle_we",       32'(ctrl_writeEnable), 32'd0);
        chk("idle_reg_hold", 32'(ctrl_writeReg),    32'd4);
        chk("idle_data_hold", data_writeReg,        32'h22222222);

        // Writeback beats a pending MD result.
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hAAAA0000;
        md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h77777777;
        #1;
        chk("wbpri_md_ready", 32'(md_ready), 32'd0);
        tick();
        chk("wbpri_reg",  32'(ctrl_writeReg), 32'd5);
        chk("wbpri_data", data_writeReg,      32'hAAAA0000);
        wb_we = 1'b0;
        #1;
        chk("wbpri_md_after", 32'(md_ready), 32'd1);
        tick();
        chk("md_after_we",   32'(ctrl_writeEnable), 32'd1);
        chk("md_after_reg",  32'(ctrl_writeReg),    32'd7);
        chk("md_after_data", data_writeReg,         32'h77777777);
        md_valid = 1'b0;
        tick();

        // Starvation: MD waits 8 cycles behind writeback, then one stall slot.
        wb_we = 1'b1;
        md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h99999999;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("starve_wait%0d_stall", i), 32'(stall_pipeline), 32'd0);
            chk($sformatf("starve_wait%0d_ready", i), 32'(md_ready),       32'd0);
            tick();
        end
        chk("starve_stall",    32'(stall_pipeline), 32'd1);
        chk("starve_md_ready", 32'(md_ready),       32'd1);
        chk("starve_wb_reg",   32'(ctrl_writeReg),  32'd5);
        tick();
        md_valid = 1'b0;
        chk("starve_stall_off", 32'(stall_pipeline),  32'd0);
        chk("starve_md_we",     32'(ctrl_writeEnable), 32'd1);
        chk("starve_md_reg",    32'(ctrl_writeReg),    32'd9);
        chk("starve_md_data",   data_writeReg,         32'h99999999);
        tick();
        chk("starve_wb_replay_reg",  32'(ctrl_writeReg), 32'd5);
        chk("starve_wb_replay_data", data_writeReg,      32'hAAAA0000);
        chk("starve_no_2nd_stall",   32'(stall_pipeline), 32'd0);
        wb_we = 1'b0;
        tick();

        // I/O write to register 0: accepted but never written.
        io_valid = 1'b1; io_reg = 5'd0; io_data = 32'hFFFFFFFF;
        #1;
        chk("r0_io_ready", 32'(io_ready), 32'd1);
        tick();
        chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
        io_valid = 1'b0;
        tick();

        // Reset in the cycle after an MD grant.
        md_valid = 1'b1; md_reg = 5'd12; md_data = 32'h0000000C;
        #1;
        chk("rstmid_md_ready", 32'(md_ready), 32'd1);
        tick();
        md_valid = 1'b0;
        chk("rstmid_we_pre", 32'(ctrl_writeEnable), 32'd1);
        ctrl_reset = 1'b0;
        #1;
        chk("rstmid_we",   32'(ctrl_writeEnable), 32'd0);
        chk("rstmid_reg",  32'(ctrl_writeReg),    32'd0);
        chk("rstmid_data", data_writeReg,         32'd0);

        // Partial starvation count must be wiped by reset.
        wb_we = 1'b1;
        md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h99999999;
        ctrl_reset = 1'b1;
        repeat (5) tick();
        ctrl_reset = 1'b0;
        #2;
        ctrl_reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rstcnt_wait%0d_stall", i), 32'(stall_pipeline), 32'd0);
            tick();
        end
        chk("rstcnt_stall", 32'(stall_pipeline), 32'd1);
        tick();
        wb_we = 1'b0;
        md_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between three writers: pipeline writeback, the multi-cycle mult/div unit, and the memory-mapped game I/O writer, which updates the controller-input and score registers.
- Pipeline writeback has fixed top priority. Mult/div and I/O share the leftover slots round-robin.
- A starvation guard stalls the pipeline for one cycle to force a slot.
- Outputs are registered and drive the register file directly.

Parameters:
- STARVE_LIMIT, 8, consecutive waiting cycles before a requester forces a pipeline stall. Legal range 2..255.
- CNT_W, 8, width of the starvation counters.

Ports:
- clock  in  1  system clock. All logic is rising-edge.
- ctrl_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_we  in  1  pipeline writeback request. No ready/back-pressure except via stall_pipeline.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- md_valid  in  1  mult/div result valid. Held stable until accepted.
- md_reg  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- md_ready  out  1  mult/div accept. Combinational.
- io_valid  in  1  I/O write valid. Held stable until accepted.
- io_reg  in  5  I/O destination register.
- io_data  in  32  I/O write data.
- io_ready  out  1  I/O accept. Combinational.
- stall_pipeline  out  1  registered. When 1, pipeline writeback must hold and re-present next cycle.
- ctrl_writeEnable  out  1  registered write enable to the register file.
- ctrl_writeReg  out  5  registered write address.
- data_writeReg  out  32  registered write data.

Behaviour:
- Reset (ctrl_reset=0, async):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - stall_pipeline=0.
  - Starvation counters = 0.
  - Round-robin pointer = MD, so MD has priority first.
- Reset mid-operation drops any in-flight grant. Requesters keep valid asserted and are re-arbitrated after reset releases.

Grant per cycle (combinational), one winner:
1. If stall_pipeline=1: wb_we is ignored. The winner is whichever requester triggered the stall. If both triggered, the round-robin pointer decides.
2. Else if wb_we=1: the pipeline wins. md_ready=0, io_ready=0.
3. Else, among md_valid and io_valid: a single valid requester wins. If both are valid, the pointer's requester wins.
- A handshake completes on valid&ready in the same cycle.
- The pointer moves to the other requester after any MD or IO grant. Pipeline grants do not move it.

Write output:
- The winner's reg and data are registered. ctrl_writeEnable=1 on the next edge, giving 1-cycle latency from grant to write.
- No winner: ctrl_writeEnable=0. ctrl_writeReg and data_writeReg hold their previous values.
- Winner targets register 0: the handshake completes, but ctrl_writeEnable stays 0. Register 0 is never written.

Starvation:
- Per requester (MD, IO), the counter increments when valid=1 and ready=0. It saturates at STARVE_LIMIT.
- The counter clears on grant or when valid=0.
- stall_pipeline is registered, =1 in the cycle after any counter reaches STARVE_LIMIT. It is a one-cycle pulse; the forced grant clears the counter.
- Never asserted on two consecutive cycles.

Ordering:
- No reordering within a requester.
- Same-register writes from different requesters commit in grant order. Software/hazard logic owns the consequences.

Optional Feature:
- REGFILE_ARB_STATS_EN defined: adds outputs stat_md_grants[15:0], stat_io_grants[15:0], stat_stalls[15:0].
  - Each is a wrapping counter of completed MD grants, completed IO grants, and stall_pipeline pulses.
  - Reset to 0 on ctrl_reset.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package:
  - Requester encoding constant REQ_NONE=0, REQ_WB=1, REQ_MD=2, REQ_IO=3.
  - REG_ZERO=5'd0.
  - Register-file geometry constants: REG_ADDR_W=5, REG_DATA_W=32.
- One natural sub-module: starve_counter (saturating counter with inc/clr, parameterised on STARVE_LIMIT and CNT_W), instantiated for MD and IO.

Test Plan:
- Reset with all requests high -> all outputs 0. First post-reset cycle with wb_we=0 grants MD; ctrl_writeEnable=1 one cycle later.
- wb_we=1 (reg 5, 0xAAAA0000) with md_valid=1 -> WB written first, md_ready=0. Next cycle wb_we=0 -> MD granted; reg/data appear the following cycle.
- md_valid and io_valid held, wb_we=0 -> grants alternate MD, IO, MD, IO; each handshake completes in 1 cycle.
- wb_we=1 every cycle, md_valid=1, STARVE_LIMIT=8 -> stall_pipeline pulses once after 8 wait cycles. MD is written that cycle; the pipeline's write is re-presented and lands next.
- io_valid with io_reg=0, io_data=0xFFFFFFFF -> io_ready=1, ctrl_writeEnable stays 0.
- ctrl_reset asserted in the cycle after an MD grant -> ctrl_writeEnable forced 0 asynchronously; counters cleared.
